sdp_ram_arbiter: RTL and testbench
==================================

SDP_RAM_ARBITER -- requirements
Module: sdp_ram_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MEM_ADDR_WIDTH, 9, RAM word address width.
- MEM_WORD_WIDTH, 64, RAM data width.
- MEM_WR_MASK_WIDTH, MEM_WORD_WIDTH/8, byte write-mask width.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- wr0_req, wr1_req  in  1  write request.
- wr0_addr, wr1_addr  in  MEM_ADDR_WIDTH  write address.
- wr0_data, wr1_data  in  MEM_WORD_WIDTH  write data.
- wr0_mask, wr1_mask  in  MEM_WR_MASK_WIDTH  byte enables.
- wr0_gnt, wr1_gnt  out  1  write accepted this cycle.
- rd0_req, rd1_req  in  1  read request.
- rd0_addr, rd1_addr  in  MEM_ADDR_WIDTH  read address.
- rd0_gnt, rd1_gnt  out  1  read accepted this cycle.
- rd0_valid, rd1_valid  out  1  read data valid.
- rd0_data, rd1_data  out  MEM_WORD_WIDTH  read data.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  MEM_ADDR_WIDTH  RAM write address.
- ram_wr_data  out  MEM_WORD_WIDTH  RAM write data.
- ram_wr_mask  out  MEM_WR_MASK_WIDTH  RAM byte mask.
- ram_rd_addr  out  MEM_ADDR_WIDTH  RAM read address.
- ram_rd_data  in  MEM_WORD_WIDTH  RAM read data, 1-cycle synchronous latency.

REQ-003 Clocking and reset: one clock (clk); reset rst is synchronous and active-high.

Function
REQ-004 The write side SHALL use a 2-way round-robin arbiter: grants are combinational from the current req and the priority pointer, and at most one wrN_gnt is high per cycle.

REQ-005 The read side SHALL use an independent 2-way round-robin arbiter with the same rules.

REQ-006 Each pointer SHALL move to favour the other requester only in cycles where a grant occurs; a lone requester SHALL be granted every cycle.

REQ-007 A write granted in cycle T SHALL appear registered on ram_wr_en/addr/data/mask in cycle T+1; ram_wr_en SHALL be 0 in cycles with no write grant.

REQ-008 A read granted in cycle T SHALL register ram_rd_addr for cycle T+1; rdN_valid SHALL assert in T+2, with rdN_data = ram_rd_data, for the granted requester only.
- No backpressure on read data.
- Full throughput: one read per cycle.

REQ-009 A 2-stage tag pipeline (valid + requester id) SHALL track in-flight reads; rdN_data SHALL hold its last value when rdN_valid=0.

REQ-010 Hazard rule: a read candidate SHALL NOT be granted if its address equals either
- the address of the write granted in the same cycle, or
- ram_wr_addr while ram_wr_en=1.
The read requester keeps priority and retries next cycle.

REQ-011 Reads and writes granted in the same cycle to different addresses SHALL both proceed.

REQ-012 Address and data SHALL pass unmodified at full width; no wrap or arithmetic is performed.

Reset
REQ-013 In any cycle with rst=1:
- all gnt, valid and ram_wr_en outputs SHALL be 0 in that cycle and the next;
- both pointers SHALL favour requester 0;
- ram_rd_addr, ram_wr_addr, ram_wr_data, ram_wr_mask and rdN_data SHALL be 0.

REQ-014 Reset mid-operation SHALL discard in-flight reads: no rdN_valid until a post-reset grant completes.

Structure
REQ-015 A shared package SHALL hold the requester-id encoding (REQ0=0, REQ1=1) and the read latency constant RD_LAT=2.

REQ-016 One sub-module, rr_arb2 (2-input round-robin arbiter with pointer), SHALL be instantiated twice, once for reads and once for writes.

REQ-017 The block SHALL NOT instantiate the RAM; the ram_* ports connect to the existing SDP RAM.

Verification
REQ-018 Contention: wr0_req and wr1_req held high for 4 cycles after reset -> grants in order 0,1,0,1.

REQ-019 Read latency: rd1 reads addr 5, which holds 64'hA5A5 -> rd1_valid=1 exactly 2 cycles after rd1_gnt, with rd1_data=64'hA5A5; rd0_valid stays 0.

REQ-020 Hazard: wr0 to addr 9 and rd0 of addr 9 in the same cycle -> wr0_gnt=1, rd0_gnt=0 for 2 cycles, then rd0_gnt=1 and rd0_data returns the new data.

REQ-021 Masked write: wr1 addr 3, mask 8'h0F, data all-ones over prior 0 -> later read returns 64'h00000000FFFFFFFF.

REQ-022 Reset mid-read: rst asserted in the cycle after rd0_gnt -> no rd0_valid; both pointers favour requester 0.

Source files
------------

// File: rtl/sdp_ram_arbiter_pkg.sv
// Shared types for the SDP RAM arbiter.
// Requester ids, read latency and the in-flight read tag.
package sdp_ram_arbiter_pkg;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  localparam int RD_LAT = 2;

  typedef struct packed {
    logic    vld;
    req_id_e id;
  } rd_tag_t;

endpackage

// File: rtl/sdp_ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a priority pointer.
// pick_o is the raw choice; kill_i vetoes it without moving the pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       kill_i,
  output logic [1:0] pick_o,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Choose a requester from the pointer, then apply the veto
  always_comb begin
    pick_o = 2'b00;
    if (!ptr_q) begin
      if (req_i[0])      pick_o = 2'b01;
      else if (req_i[1]) pick_o = 2'b10;
    end else begin
      if (req_i[1])      pick_o = 2'b10;
      else if (req_i[0]) pick_o = 2'b01;
    end
    gnt_o = kill_i ? 2'b00 : pick_o;
    ptr_d = ptr_q;
    if (gnt_o[0]) ptr_d = 1'b1;
    if (gnt_o[1]) ptr_d = 1'b0;
  end

  // Pointer only moves on a real grant
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Two-writer / two-reader arbiter in front of a simple dual-port RAM.
// Reads are held off while a write to the same address is in flight.
module sdp_ram_arbiter
  import sdp_ram_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH    = 9,
  parameter int MEM_WORD_WIDTH    = 64,
  parameter int MEM_WR_MASK_WIDTH = MEM_WORD_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr0_req,
  input  logic                         wr1_req,
  input  logic [MEM_ADDR_WIDTH-1:0]    wr0_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]    wr1_addr,
  input  logic [MEM_WORD_WIDTH-1:0]    wr0_data,
  input  logic [MEM_WORD_WIDTH-1:0]    wr1_data,
  input  logic [MEM_WR_MASK_WIDTH-1:0] wr0_mask,
  input  logic [MEM_WR_MASK_WIDTH-1:0] wr1_mask,
  output logic                         wr0_gnt,
  output logic                         wr1_gnt,
  input  logic                         rd0_req,
  input  logic                         rd1_req,
  input  logic [MEM_ADDR_WIDTH-1:0]    rd0_addr,
  input  logic [MEM_ADDR_WIDTH-1:0]    rd1_addr,
  output logic                         rd0_gnt,
  output logic                         rd1_gnt,
  output logic                         rd0_valid,
  output logic                         rd1_valid,
  output logic [MEM_WORD_WIDTH-1:0]    rd0_data,
  output logic [MEM_WORD_WIDTH-1:0]    rd1_data,
  output logic                         ram_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0]    ram_wr_addr,
  output logic [MEM_WORD_WIDTH-1:0]    ram_wr_data,
  output logic [MEM_WR_MASK_WIDTH-1:0] ram_wr_mask,
  output logic [MEM_ADDR_WIDTH-1:0]    ram_rd_addr,
  input  logic [MEM_WORD_WIDTH-1:0]    ram_rd_data
);

  logic       rst_q;
  logic       blk;
  logic [1:0] wpick;
  logic [1:0] wgnt;
  logic [1:0] rpick;
  logic [1:0] rgnt;
  logic       hazard;

  logic [MEM_ADDR_WIDTH-1:0]    w_addr;
  logic [MEM_WORD_WIDTH-1:0]    w_data;
  logic [MEM_WR_MASK_WIDTH-1:0] w_mask;
  logic [MEM_ADDR_WIDTH-1:0]    r_addr;

  logic                         wr_en_q;
  logic [MEM_ADDR_WIDTH-1:0]    wr_addr_q;
  logic [MEM_WORD_WIDTH-1:0]    wr_data_q;
  logic [MEM_WR_MASK_WIDTH-1:0] wr_mask_q;
  logic [MEM_ADDR_WIDTH-1:0]    rd_addr_q;
  rd_tag_t                      tag_q [RD_LAT];
  rd_tag_t                      tag_d;
  logic [MEM_WORD_WIDTH-1:0]    rd0_hold_q;
  logic [MEM_WORD_WIDTH-1:0]    rd1_hold_q;
  logic                         v0;
  logic                         v1;

  // Grants are suppressed in the reset cycle and the one after it
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign blk = rst | rst_q;

  rr_arb2 u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({wr1_req, wr0_req}),
    .kill_i (blk),
    .pick_o (wpick),
    .gnt_o  (wgnt)
  );

  rr_arb2 u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({rd1_req, rd0_req}),
    .kill_i (blk | hazard),
    .pick_o (rpick),
    .gnt_o  (rgnt)
  );

  // Winner muxes and the read-after-write hazard on the read candidate
  always_comb begin
    w_addr = wgnt[1] ? wr1_addr : wr0_addr;
    w_data = wgnt[1] ? wr1_data : wr0_data;
    w_mask = wgnt[1] ? wr1_mask : wr0_mask;
    r_addr = rpick[1] ? rd1_addr : rd0_addr;
    hazard = 1'b0;
    if ((|wgnt) && (r_addr == w_addr))
      hazard = 1'b1;
    if (wr_en_q && (r_addr == wr_addr_q))
      hazard = 1'b1;
    tag_d.vld = |rgnt;
    tag_d.id  = rgnt[1] ? REQ1 : REQ0;
  end

  // RAM-side write/read registers and the read tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_mask_q <= '0;
      rd_addr_q <= '0;
      for (int i = 0; i < RD_LAT; i++)
        tag_q[i] <= '0;
    end else begin
      wr_en_q <= |wgnt;
      if (|wgnt) begin
        wr_addr_q <= w_addr;
        wr_data_q <= w_data;
        wr_mask_q <= w_mask;
      end
      if (|rgnt)
        rd_addr_q <= r_addr;
      tag_q[0] <= tag_d;
      for (int i = 1; i < RD_LAT; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  assign v0 = tag_q[RD_LAT-1].vld && (tag_q[RD_LAT-1].id == REQ0);
  assign v1 = tag_q[RD_LAT-1].vld && (tag_q[RD_LAT-1].id == REQ1);

  // Last returned word per requester, held between valids
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_hold_q <= '0;
      rd1_hold_q <= '0;
    end else begin
      if (v0) rd0_hold_q <= ram_rd_data;
      if (v1) rd1_hold_q <= ram_rd_data;
    end
  end

  assign wr0_gnt     = wgnt[0];
  assign wr1_gnt     = wgnt[1];
  assign rd0_gnt     = rgnt[0];
  assign rd1_gnt     = rgnt[1];
  assign rd0_valid   = v0 & ~rst;
  assign rd1_valid   = v1 & ~rst;
  assign rd0_data    = rst ? '0 : (v0 ? ram_rd_data : rd0_hold_q);
  assign rd1_data    = rst ? '0 : (v1 ? ram_rd_data : rd1_hold_q);
  assign ram_wr_en   = wr_en_q & ~rst;
  assign ram_wr_addr = rst ? '0 : wr_addr_q;
  assign ram_wr_data = rst ? '0 : wr_data_q;
  assign ram_wr_mask = rst ? '0 : wr_mask_q;
  assign ram_rd_addr = rst ? '0 : rd_addr_q;

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Directed bench for sdp_ram_arbiter with a behavioural SDP RAM.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_sdp_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr0_req, wr1_req;
  logic [AW-1:0] wr0_addr, wr1_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [MW-1:0] wr0_mask, wr1_mask;
  logic          wr0_gnt, wr1_gnt;
  logic          rd0_req, rd1_req;
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic          rd0_gnt, rd1_gnt;
  logic          rd0_valid, rd1_valid;
  logic [DW-1:0] rd0_data, rd1_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [MW-1:0] ram_wr_mask;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] mem [2**AW];

  always #5 clk = ~clk;

  sdp_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .wr0_req(wr0_req), .wr1_req(wr1_req),
    .wr0_addr(wr0_addr), .wr1_addr(wr1_addr),
    .wr0_data(wr0_data), .wr1_data(wr1_data),
    .wr0_mask(wr0_mask), .wr1_mask(wr1_mask),
    .wr0_gnt(wr0_gnt), .wr1_gnt(wr1_gnt),
    .rd0_req(rd0_req), .rd1_req(rd1_req),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_gnt(rd0_gnt), .rd1_gnt(rd1_gnt),
    .rd0_valid(rd0_valid), .rd1_valid(rd1_valid),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_wr_mask(ram_wr_mask),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // Behavioural SDP RAM: byte-masked write, 1-cycle read
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < MW; b++)
        if (ram_wr_mask[b])
          mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0_req = 0; wr1_req = 0;
    rd0_req = 0; rd1_req = 0;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1;
    wr0_req = 1; wr1_req = 1; rd0_req = 1; rd1_req = 1;
    wr0_addr = 1; wr1_addr = 2; rd0_addr = 3; rd1_addr = 4;
    #1;
    nvec++;
    if ({wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt} !== 4'b0) begin
      nerr++;
      $display("FAIL rst_gnt got %b exp 0000",
               {wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt});
    end
    nvec++;
    if ({ram_wr_en, rd0_valid, rd1_valid} !== 3'b0) begin
      nerr++;
      $display("FAIL rst_en_vld got %b exp 000",
               {ram_wr_en, rd0_valid, rd1_valid});
    end
    cyc();
    #1;
    nvec++;
    if ({ram_rd_addr, ram_wr_addr, ram_wr_mask} !== '0 ||
        rd0_data !== '0 || rd1_data !== '0 || ram_wr_data !== '0) begin
      nerr++;
      $display("FAIL rst_regs rd_addr %h wr_addr %h rd0 %h",
               ram_rd_addr, ram_wr_addr, rd0_data);
    end
    cyc();
    rst = 0;
    #1;
    nvec++;
    if ({wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt} !== 4'b0) begin
      nerr++;
      $display("FAIL post_rst_gnt got %b exp 0000",
               {wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt});
    end
    idle();
  endtask

  task automatic test_contention();
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      cyc();
      wr0_req = 1; wr1_req = 1;
      wr0_addr = AW'(20 + 2 * i);
      wr1_addr = AW'(21 + 2 * i);
      wr0_data = DW'(100 + i); wr1_data = DW'(200 + i);
      wr0_mask = '1; wr1_mask = '1;
      #1;
      nvec++;
      if ({wr1_gnt, wr0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        nerr++;
        $display("FAIL contention_%0d got %b exp %b", i,
                 {wr1_gnt, wr0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    cyc();
    idle();
    #1;
    a = AW'(20 + 7);
    nvec++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== a ||
        ram_wr_data !== DW'(203)) begin
      nerr++;
      $display("FAIL contention_wr got en %b addr %0d data %0d exp 1 27 203",
               ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    cyc();
    #1;
    nvec++;
    if (ram_wr_en !== 1'b0) begin
      nerr++;
      $display("FAIL wr_en_idle got %b exp 0", ram_wr_en);
    end
  endtask

  task automatic test_read_latency();
    cyc();
    rd1_req = 1; rd1_addr = 5;
    #1;
    nvec++;
    if (rd1_gnt !== 1'b1 || rd0_gnt !== 1'b0) begin
      nerr++;
      $display("FAIL rd1_gnt got %b%b exp 10", rd1_gnt, rd0_gnt);
    end
    cyc();
    idle();
    #1;
    nvec++;
    if (ram_rd_addr !== AW'(5) || rd1_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rd1_t1 got addr %0d vld %b exp 5 0",
               ram_rd_addr, rd1_valid);
    end
    cyc();
    #1;
    nvec++;
    if (rd1_valid !== 1'b1 || rd1_data !== 64'hA5A5 ||
        rd0_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rd1_t2 got vld %b data %h rd0v %b exp 1 a5a5 0",
               rd1_valid, rd1_data, rd0_valid);
    end
    cyc();
    #1;
    nvec++;
    if (rd1_valid !== 1'b0 || rd1_data !== 64'hA5A5) begin
      nerr++;
      $display("FAIL rd1_hold got vld %b data %h exp 0 a5a5",
               rd1_valid, rd1_data);
    end
  endtask

  task automatic test_hazard();
    cyc();
    wr0_req = 1; wr0_addr = 9;
    wr0_data = 64'h1234_5678_9ABC_DEF0; wr0_mask = '1;
    rd0_req = 1; rd0_addr = 9;
    #1;
    nvec++;
    if (wr0_gnt !== 1'b1 || rd0_gnt !== 1'b0) begin
      nerr++;
      $display("FAIL haz_t0 got wr %b rd %b exp 1 0", wr0_gnt, rd0_gnt);
    end
    cyc();
    wr0_req = 0;
    #1;
    nvec++;
    if (rd0_gnt !== 1'b0 || ram_wr_en !== 1'b1) begin
      nerr++;
      $display("FAIL haz_t1 got rd %b en %b exp 0 1", rd0_gnt, ram_wr_en);
    end
    cyc();
    #1;
    nvec++;
    if (rd0_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL haz_t2 got rd %b exp 1", rd0_gnt);
    end
    cyc();
    idle();
    cyc();
    #1;
    nvec++;
    if (rd0_valid !== 1'b1 || rd0_data !== 64'h1234_5678_9ABC_DEF0) begin
      nerr++;
      $display("FAIL haz_data got vld %b data %h exp 1 123456789abcdef0",
               rd0_valid, rd0_data);
    end
  endtask

  task automatic test_masked_write();
    cyc();
    wr1_req = 1; wr1_addr = 3; wr1_data = '1; wr1_mask = 8'h0F;
    #1;
    nvec++;
    if (wr1_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL mask_gnt got %b exp 1", wr1_gnt);
    end
    cyc();
    idle();
    #1;
    nvec++;
    if (ram_wr_mask !== 8'h0F || ram_wr_addr !== AW'(3)) begin
      nerr++;
      $display("FAIL mask_port got mask %h addr %0d exp 0f 3",
               ram_wr_mask, ram_wr_addr);
    end
    cyc();
    rd0_req = 1; rd0_addr = 3;
    #1;
    nvec++;
    if (rd0_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL mask_rd_gnt got %b exp 1", rd0_gnt);
    end
    cyc();
    idle();
    cyc();
    #1;
    nvec++;
    if (rd0_valid !== 1'b1 || rd0_data !== 64'h0000_0000_FFFF_FFFF) begin
      nerr++;
      $display("FAIL mask_data got vld %b data %h exp 1 00000000ffffffff",
               rd0_valid, rd0_data);
    end
  endtask

  task automatic test_same_cycle();
    cyc();
    wr0_req = 1; wr0_addr = 30; wr0_data = 64'hBEEF; wr0_mask = '1;
    rd1_req = 1; rd1_addr = 5;
    #1;
    nvec++;
    if (wr0_gnt !== 1'b1 || rd1_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL same_cycle got wr %b rd %b exp 1 1", wr0_gnt, rd1_gnt);
    end
    cyc();
    idle();
    cyc();
    #1;
    nvec++;
    if (rd1_valid !== 1'b1 || rd1_data !== 64'hA5A5) begin
      nerr++;
      $display("FAIL same_cycle_rd got vld %b data %h exp 1 a5a5",
               rd1_valid, rd1_data);
    end
  endtask

  task automatic test_reset_mid_read();
    cyc();
    rd0_req = 1; rd0_addr = 5;
    #1;
    nvec++;
    if (rd0_gnt !== 1'b1) begin
      nerr++;
      $display("FAIL mid_gnt got %b exp 1", rd0_gnt);
    end
    cyc();
    idle();
    rst = 1;
    #1;
    nvec++;
    if (rd0_valid !== 1'b0 || ram_rd_addr !== '0) begin
      nerr++;
      $display("FAIL mid_rst got vld %b addr %0d exp 0 0",
               rd0_valid, ram_rd_addr);
    end
    cyc();
    rst = 0;
    #1;
    nvec++;
    if (rd0_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_post1 got vld %b exp 0", rd0_valid);
    end
    cyc();
    wr0_req = 1; wr1_req = 1; wr0_addr = 40; wr1_addr = 43;
    rd0_req = 1; rd1_req = 1; rd0_addr = 41; rd1_addr = 42;
    #1;
    nvec++;
    if (rd0_valid !== 1'b0) begin
      nerr++;
      $display("FAIL mid_post2 got vld %b exp 0", rd0_valid);
    end
    nvec++;
    if ({wr1_gnt, wr0_gnt, rd1_gnt, rd0_gnt} !== 4'b0101) begin
      nerr++;
      $display("FAIL mid_ptr got %b exp 0101",
               {wr1_gnt, wr0_gnt, rd1_gnt, rd0_gnt});
    end
    cyc();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    mem[5] = 64'hA5A5;
    ram_rd_data = '0;
    rst = 1;
    idle();
    wr0_addr = '0; wr1_addr = '0; rd0_addr = '0; rd1_addr = '0;
    wr0_data = '0; wr1_data = '0; wr0_mask = '0; wr1_mask = '0;
    test_reset();
    test_contention();
    test_read_latency();
    test_hazard();
    test_masked_write();
    test_same_cycle();
    test_reset_mid_read();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
